// File: rtl/gb_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : gb_mixer_if
// Brief    : Channel/register inputs and L/R sample outputs of gb_mixer.
//            GB_MIXER_POWER_EN adds the NR52 power bit.
// Revision : 1.0 - initial release
// ============================================================================
interface gb_mixer_if;
    logic [3:0] ch1;
    logic [3:0] ch2;
    logic [3:0] ch3;
    logic [3:0] ch4;
    logic [7:0] nr50;
    logic [7:0] nr51;
`ifdef GB_MIXER_POWER_EN
    logic       power;
`endif
    logic [3:0] left;
    logic [3:0] right;
    logic       sample_valid;

`ifdef GB_MIXER_POWER_EN
    modport master (
        output ch1, ch2, ch3, ch4, nr50, nr51, power,
        input  left, right, sample_valid
    );
    modport slave (
        input  ch1, ch2, ch3, ch4, nr50, nr51, power,
        output left, right, sample_valid
    );
`else
    modport master (
        output ch1, ch2, ch3, ch4, nr50, nr51,
        input  left, right, sample_valid
    );
    modport slave (
        input  ch1, ch2, ch3, ch4, nr50, nr51,
        output left, right, sample_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/gb_mixer.sv
`default_nettype none
// ============================================================================
// Module   : gb_mixer
// Brief    : Sequential four-channel L/R mixer, NR51 panning, NR50 volume.
//            Optional macro GB_MIXER_POWER_EN gates the mixer with bus.power.
// Revision : 1.0 - initial release
// ============================================================================
module gb_mixer #(
    parameter int SAMPLE_TIME = 128,
    parameter int CNT_W       = $clog2(SAMPLE_TIME)
) (
    input  wire       clk,
    input  wire       rst_n,
    gb_mixer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TICK = CNT_W'(SAMPLE_TIME - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic             w_run;
    logic             w_snap;
    logic             w_acc;
    logic             w_scale;

    logic [1:0]       r_idx;
    logic [3:0]       r_ch [4];
    logic [2:0]       r_lvol;
    logic [2:0]       r_rvol;
    logic [7:0]       r_nr51;
    logic [5:0]       r_acc_l;
    logic [5:0]       r_acc_r;
    logic [3:0]       w_add_l;
    logic [3:0]       w_add_r;
    logic [8:0]       w_prod_l;
    logic [8:0]       w_prod_r;
    logic [3:0]       w_left_next;
    logic [3:0]       w_right_next;
    logic [3:0]       r_left;
    logic [3:0]       r_right;
    logic             r_valid;

    // VIN enables (NR50 bits 7 and 3) have no cartridge audio path here.
    logic             w_unused_vin;
    assign w_unused_vin = ^{bus.nr50[7], bus.nr50[3]};

`ifdef GB_MIXER_POWER_EN
    assign w_run = bus.power;
`else
    assign w_run = 1'b1;
`endif

    assign w_tick = (r_cnt == c_TICK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A tick outside IDLE cannot start a new sample; it is simply dropped.
    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_acc        = 1'b0;
        w_scale      = 1'b0;
        if (!w_run) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        w_snap       = 1'b1;
                        w_state_next = ST_ACC;
                    end
                end
                ST_ACC: begin
                    w_acc = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_state_next = ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    w_scale      = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_add_l = r_nr51[{1'b1, r_idx}] ? r_ch[r_idx] : 4'd0;
    assign w_add_r = r_nr51[{1'b0, r_idx}] ? r_ch[r_idx] : 4'd0;

    // Worst case 60 * 8 = 480 fits in 9 bits, so the >>5 result never exceeds 15.
    assign w_prod_l     = {3'b000, r_acc_l} * {5'b00000, ({1'b0, r_lvol} + 4'd1)};
    assign w_prod_r     = {3'b000, r_acc_r} * {5'b00000, ({1'b0, r_rvol} + 4'd1)};
    assign w_left_next  = 4'(w_prod_l >> 5);
    assign w_right_next = 4'(w_prod_r >> 5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_ch[i] <= '0;
            end
            r_lvol  <= '0;
            r_rvol  <= '0;
            r_nr51  <= '0;
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_valid <= 1'b0;
        end else if (!w_run) begin
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_snap) begin
                r_ch[0] <= bus.ch1;
                r_ch[1] <= bus.ch2;
                r_ch[2] <= bus.ch3;
                r_ch[3] <= bus.ch4;
                r_lvol  <= bus.nr50[6:4];
                r_rvol  <= bus.nr50[2:0];
                r_nr51  <= bus.nr51;
                r_idx   <= '0;
                r_acc_l <= '0;
                r_acc_r <= '0;
            end
            if (w_acc) begin
                r_acc_l <= r_acc_l + {2'b00, w_add_l};
                r_acc_r <= r_acc_r + {2'b00, w_add_r};
                r_idx   <= r_idx + 2'd1;
            end
            if (w_scale) begin
                r_left  <= w_left_next;
                r_right <= w_right_next;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.left         = r_left;
    assign bus.right        = r_right;
    assign bus.sample_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_gb_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_mixer
// Brief    : Scoreboard bench for gb_mixer; random and directed mixes against
//            an arithmetic panning/volume model. Covers GB_MIXER_POWER_EN too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_mixer;

    localparam int ST = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gb_mixer_if bus();

    gb_mixer #(.SAMPLE_TIME(ST)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q [$];
    logic [3:0] last_l   = 4'd0;
    logic [3:0] last_r   = 4'd0;
    bit         hold_en  = 1'b1;

    // cyc == n after the n-th edge since release; the tick edge is cyc == k*ST.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mix(input int c1, input int c2, input int c3,
                                       input int c4, input int nr50, input int nr51);
        int ch [4];
        int sl;
        int sr;
        int l;
        int r;
        ch = '{c1, c2, c3, c4};
        sl = 0;
        sr = 0;
        for (int i = 0; i < 4; i++) begin
            if (((nr51 >> (4 + i)) & 1) == 1) sl += ch[i];
            if (((nr51 >> i) & 1) == 1)       sr += ch[i];
        end
        l = (sl * (((nr50 >> 4) & 7) + 1)) / 32;
        r = (sr * ((nr50 & 7) + 1)) / 32;
        return {l[3:0], r[3:0]};
    endfunction

    task automatic wait_phase(input int p);
        int budget;
        budget = 2 * ST + 8;
        do begin
            @(negedge clk);
            budget--;
        end while (((cyc % ST) != p) && (budget > 0));
        if ((cyc % ST) != p) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase: phase %0d, required %0d", cyc % ST, p);
        end
    endtask

    // Inputs change mid-period so the following tick samples them.
    task automatic issue(input int c1, input int c2, input int c3, input int c4,
                         input int nr50, input int nr51);
        wait_phase(ST / 2);
        bus.ch1  = 4'(c1);
        bus.ch2  = 4'(c2);
        bus.ch3  = 4'(c3);
        bus.ch4  = 4'(c4);
        bus.nr50 = 8'(nr50);
        bus.nr51 = 8'(nr51);
        exp_q.push_back(mix(c1, c2, c3, c4, nr50, nr51));
    endtask

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (bus.sample_valid) begin
                check("strobe_phase", cyc % ST, 5);
                check("strobe_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("left", int'(bus.left), int'(e[7:4]));
                    check("right", int'(bus.right), int'(e[3:0]));
                    last_l = e[7:4];
                    last_r = e[3:0];
                end
            end else begin
                if (((cyc % ST) == 5) && (cyc > ST) && (exp_q.size() != 0)) begin
                    check("strobe_present", int'(bus.sample_valid), 1);
                    e = exp_q.pop_front();
                    last_l = e[7:4];
                    last_r = e[3:0];
                end
                if (hold_en) begin
                    check("hold_left", int'(bus.left), int'(last_l));
                    check("hold_right", int'(bus.right), int'(last_r));
                end
            end
        end
    end

    initial begin
        bus.ch1  = 4'd0;
        bus.ch2  = 4'd0;
        bus.ch3  = 4'd0;
        bus.ch4  = 4'd0;
        bus.nr50 = 8'h00;
        bus.nr51 = 8'h00;
`ifdef GB_MIXER_POWER_EN
        bus.power = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_left", int'(bus.left), 0);
        check("reset_right", int'(bus.right), 0);
        check("reset_valid", int'(bus.sample_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) issue(15, 15, 15, 15, 8'h77, 8'hFF);
        issue(8, 4, 0, 0, 8'h77, 8'h12);
        issue(15, 15, 15, 15, 8'h30, 8'hFF);

        // Snapshot: every live input is disturbed before the first accumulate.
        issue(15, 5, 0, 0, 8'h77, 8'h11);
        wait_phase(0);
        bus.ch1  = 4'd0;
        bus.nr50 = 8'h00;
        bus.nr51 = 8'hFF;
        issue(0, 5, 0, 0, 8'h77, 8'h11);

        for (int i = 0; i < 20; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Asynchronous reset while the FSM sits in SCALE.
        issue(15, 15, 15, 15, 8'h77, 8'hFF);
        issue(15, 15, 15, 15, 8'h77, 8'hFF);
        wait_phase(4);
        rst_n = 1'b0;
        #1;
        check("midscale_left", int'(bus.left), 0);
        check("midscale_right", int'(bus.right), 0);
        check("midscale_valid", int'(bus.sample_valid), 0);
        exp_q.delete();
        last_l = 4'd0;
        last_r = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(15, 15, 15, 15, 8'h77, 8'hFF);
        issue(3, 9, 12, 7, 8'h52, 8'h6B);

`ifdef GB_MIXER_POWER_EN
        wait_phase(ST / 2);
        hold_en   = 1'b0;
        bus.power = 1'b0;
        repeat (2) @(negedge clk);
        check("poweroff_left", int'(bus.left), 0);
        check("poweroff_right", int'(bus.right), 0);
        last_l  = 4'd0;
        last_r  = 4'd0;
        hold_en = 1'b1;
        wait_phase(ST / 2);
        wait_phase(ST / 2);
        issue(15, 15, 15, 15, 8'h77, 8'hFF);
        bus.power = 1'b1;
`endif

        wait_phase(ST / 4);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
